yarp_fetch_unit: RTL

Parametrised instruction-fetch front end for the YARP core, for the pipelined core generation. It owns the fetch PC and issues requests over a req/gnt/rvalid memory interface that tolerates variable latency and multiple outstanding requests. It buffers returned instructions, with their PCs, in a small FIFO feeding decode through a valid/ready handshake. It also supports redirects (branch/jump/trap) that flush in-flight and buffered instructions.

---
 rtl/yarp_fetch_unit_if.sv | 46 ++++
 rtl/yarp_fetch_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/yarp_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : yarp_fetch_unit_if
// Purpose  : Bundles the YARP fetch unit's redirect input, memory
//            req/gnt/rvalid bus and decode valid/ready handshake.
// Signals  : redirect_i, redirect_pc_i            - flush/restart request
//            mem_req_o, mem_addr_o, mem_gnt_i,
//            mem_rvalid_i, mem_rdata_i             - instruction memory bus
//            instr_valid_o, instr_o, instr_pc_o,
//            instr_ready_i                         - decode handshake
// Modports : master - the fetch unit's view
//            slave  - the environment's view (core control, memory, decode)
// Revision : 1.0 - initial release
// ============================================================================
interface yarp_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [31:0]     mem_rdata_i;
  logic            instr_valid_o;
  logic [31:0]     instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic            instr_ready_i;

  modport master (
    input  redirect_i, redirect_pc_i,
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output instr_valid_o, instr_o, instr_pc_o,
    input  instr_ready_i
  );

  modport slave (
    output redirect_i, redirect_pc_i,
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  instr_valid_o, instr_o, instr_pc_o,
    output instr_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/yarp_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : yarp_fetch_unit
// Purpose  : Instruction-fetch front end. Owns the fetch PC, issues word
//            fetches on a pipelined req/gnt/rvalid bus with multiple
//            outstanding requests, buffers returned instructions with their
//            PCs in a DEPTH-entry FIFO, and hands them to decode through a
//            valid/ready handshake. Redirects flush buffered and in-flight
//            instructions and restart fetch at a new PC.
// Ports    : clk      - clock
//            reset_n  - asynchronous active-low reset
//            bus      - yarp_fetch_unit_if.master (redirect, memory, decode)
// Revision : 1.0 - initial release
// ============================================================================
module yarp_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  yarp_fetch_unit_if.master bus
);

  localparam int              c_ptr_w = $clog2(DEPTH);
  localparam int              c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(DEPTH);

  logic               r_req;
  logic [XLEN-1:0]    r_fetch_pc;
  logic [XLEN-1:0]    r_resp_pc;
  logic [c_cnt_w-1:0] r_outstanding;
  logic [c_cnt_w-1:0] r_discard;
  logic [c_cnt_w-1:0] r_count;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [31:0]        r_instr [DEPTH];
  logic [XLEN-1:0]    r_pc    [DEPTH];

  logic               w_hs;
  logic               w_rsp;
  logic               w_drop;
  logic               w_push;
  logic               w_pop;
  logic               w_credit;
  logic [c_cnt_w-1:0] w_out_next;
  logic [c_cnt_w-1:0] w_cnt_next;
  logic [c_cnt_w:0]   w_total_next;
  logic [XLEN-1:0]    w_redirect_pc;

  assign w_hs   = r_req & bus.mem_gnt_i;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp  = bus.mem_rvalid_i & (r_outstanding != '0);
  assign w_drop = w_rsp & (bus.redirect_i | (r_discard != '0));
  assign w_push = w_rsp & ~w_drop;
  assign w_pop  = bus.instr_valid_o & bus.instr_ready_i;

  assign w_out_next = r_outstanding + c_cnt_w'(w_hs) - c_cnt_w'(w_rsp);
  assign w_cnt_next = bus.redirect_i ? '0
                    : r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

  // Credit is judged on next-cycle occupancy so the registered request can
  // never overcommit buffer space; occupancy cannot grow without a grant,
  // so a stalled request stays legal until granted.
  assign w_total_next = {1'b0, w_out_next} + {1'b0, w_cnt_next};
  assign w_credit     = w_total_next < c_depth;

  assign w_redirect_pc = bus.redirect_pc_i & ~XLEN'(3);

  assign bus.mem_req_o     = r_req;
  assign bus.mem_addr_o    = r_fetch_pc;
  assign bus.instr_valid_o = (r_count != '0) & ~bus.redirect_i;
  assign bus.instr_o       = r_instr[r_rd_ptr];
  assign bus.instr_pc_o    = r_pc[r_rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req         <= 1'b0;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
      end
    end else begin
      r_req         <= ~bus.redirect_i & w_credit;
      r_outstanding <= w_out_next;
      r_count       <= w_cnt_next;
      if (bus.redirect_i) begin
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        // Everything still in flight after this cycle belongs to the old path.
        r_discard  <= w_out_next;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
      end else begin
        if (w_hs) begin
          r_fetch_pc <= r_fetch_pc + XLEN'(4);
        end
        if (w_drop) begin
          r_discard <= r_discard - c_cnt_w'(1);
        end
        if (w_push) begin
          r_instr[r_wr_ptr] <= bus.mem_rdata_i;
          r_pc[r_wr_ptr]    <= r_resp_pc;
          r_wr_ptr          <= r_wr_ptr + c_ptr_w'(1);
          r_resp_pc         <= r_resp_pc + XLEN'(4);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        end
      end
    end
  end

`ifndef SYNTHESIS
  a_no_spurious_rvalid : assert property (
    @(posedge clk) disable iff (!reset_n)
    bus.mem_rvalid_i |-> (r_outstanding != '0)
  );

  a_occupancy_bound : assert property (
    @(posedge clk) disable iff (!reset_n)
    ({1'b0, r_outstanding} + {1'b0, r_count}) <= c_depth
  );
`endif

endmodule
`default_nettype wire
